// File: rtl/uart_rx.sv
// uart_rx: oversampled 8N1 serial receiver with mid-bit sampling and frame error pulse
module uart_rx #(
  parameter int DATA_BITS = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 uclk,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] dout,
  output logic                 rx_done,
  output logic                 frame_err
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BLAST = BW'(DATA_BITS - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t               state;
  logic                 rx_m, rx_s;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m      <= 1'b1;
      rx_s      <= 1'b1;
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      dout      <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_m      <= rx;
      rx_s      <= rx_m;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      if (uclk) begin
        case (state)
          IDLE: if (!rx_s) begin
            state    <= START;
            tick_cnt <= '0;
          end
          START: if (tick_cnt == HALF) begin
            state    <= rx_s ? IDLE : DATA;
            tick_cnt <= '0;
            bit_cnt  <= '0;
          end else tick_cnt <= tick_cnt + 1'b1;
          DATA: if (tick_cnt == LAST) begin
            shreg    <= {rx_s, shreg[DATA_BITS-1:1]};
            tick_cnt <= '0;
            if (bit_cnt == BLAST) state <= STOP;
            else bit_cnt <= bit_cnt + 1'b1;
          end else tick_cnt <= tick_cnt + 1'b1;
          STOP: if (tick_cnt == LAST) begin
            if (rx_s) dout <= shreg;
            rx_done   <= rx_s;
            frame_err <= !rx_s;
            state     <= IDLE;
            tick_cnt  <= '0;
          end else tick_cnt <= tick_cnt + 1'b1;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: tick-indexed line model parsed into frame events, compared every clk
module tb_uart_rx;
  localparam int MAXT = 8000;
  logic       clk = 1'b0, rst = 1'b1, uclk = 1'b0, rx = 1'b1;
  logic [7:0] dout;
  logic       rx_done, frame_err;
  uart_rx dut (
    .clk(clk), .rst(rst), .uclk(uclk), .rx(rx),
    .dout(dout), .rx_done(rx_done), .frame_err(frame_err)
  );
  always #5 clk = ~clk;
  bit         line [MAXT];
  int         evt [MAXT];
  logic [7:0] byt [MAXT];
  int         len = 0;
  int         checks = 0, errors = 0, n_done = 0, n_err = 0;
  bit         chk_en = 1'b0;
  int         evt_in = 0;
  logic [7:0] byte_in = '0;
  logic       e_done = 1'b0, e_err = 1'b0;
  logic [7:0] e_dout = '0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 20) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    if (rst) begin
      e_done <= 1'b0;
      e_err  <= 1'b0;
      e_dout <= '0;
    end else begin
      e_done <= uclk && evt_in == 1;
      e_err  <= uclk && evt_in == 2;
      if (uclk && evt_in == 1) e_dout <= byte_in;
    end
  end
  always @(negedge clk) begin
    if (chk_en) begin
      chk("rx_done", 32'(rx_done), 32'(e_done));
      chk("frame_err", 32'(frame_err), 32'(e_err));
      chk("dout", 32'(dout), 32'(e_dout));
      chk("exclusive", 32'(rx_done & frame_err), 32'd0);
      n_done += int'(rx_done);
      n_err += int'(frame_err);
    end
  end
  task automatic push(input bit v, input int n);
    for (int i = 0; i < n; i++) begin
      line[len] = v;
      len++;
    end
  endtask
  task automatic frame(input logic [7:0] b, input bit stop);
    push(1'b0, 16);
    for (int i = 0; i < 8; i++) push(b[i], 16);
    push(stop, 16);
  endtask
  // a low tick starts a frame; mid-start, mid-data and stop samples sit 8+16k ticks later
  task automatic model();
    int t = 0;
    int t0;
    logic [7:0] b;
    for (int i = 0; i < len; i++) begin
      evt[i] = 0;
      byt[i] = '0;
    end
    while (t < len) begin
      if (line[t]) t++;
      else begin
        t0 = t;
        if (t0 + 8 >= len) break;
        if (line[t0+8]) t = t0 + 9;
        else begin
          if (t0 + 152 >= len) break;
          for (int i = 0; i < 8; i++) b[i] = line[t0+24+16*i];
          evt[t0+152] = line[t0+152] ? 1 : 2;
          byt[t0+152] = b;
          t = t0 + 153;
        end
      end
    end
  endtask
  task automatic run(input int n, input int freeze_at);
    int g;
    for (int t = 0; t < n; t++) begin
      rx = line[t];
      g = (t == freeze_at) ? 5000 : int'($urandom_range(2, 4));
      repeat (g) begin
        @(posedge clk);
        #1;
      end
      uclk = 1'b1;
      evt_in = evt[t];
      byte_in = byt[t];
      @(posedge clk);
      #1;
      uclk = 1'b0;
      evt_in = 0;
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    rx = 1'b1;
    uclk = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_done", 32'(rx_done), 32'd0);
    chk("rst_err", 32'(frame_err), 32'd0);
    rst = 1'b0;
  endtask
  initial begin
    int nd, ne;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    do_reset();
    len = 0;
    push(1'b1, 5);
    frame(8'hA5, 1'b1);
    push(1'b1, 4);
    push(1'b0, 3);
    push(1'b1, 20);
    frame(8'h3C, 1'b0);
    push(1'b1, 12);
    model();
    chk("model_a5_evt", 32'(evt[157]), 32'd1);
    chk("model_a5_byte", 32'(byt[157]), 32'hA5);
    chk("model_3c_evt", 32'(evt[344]), 32'd2);
    run(len, -1);
    chk("seg1_dout", 32'(dout), 32'hA5);
    chk("seg1_done", 32'(n_done), 32'd1);
    chk("seg1_err", 32'(n_err), 32'd1);
    len = 0;
    push(1'b1, 3);
    frame(8'hFF, 1'b1);
    model();
    run(3 + 16 + 64 + 8, -1);
    do_reset();
    len = 0;
    push(1'b1, 6);
    frame(8'h0F, 1'b1);
    push(1'b1, 12);
    model();
    run(len, -1);
    chk("seg2_dout", 32'(dout), 32'h0F);
    chk("seg2_done", 32'(n_done), 32'd2);
    len = 0;
    push(1'b1, 4);
    frame(8'h00, 1'b1);
    frame(8'hFF, 1'b1);
    push(1'b1, 12);
    model();
    chk("model_b2b_evt", 32'(evt[156]), 32'd1);
    chk("model_b2b_byte", 32'(byt[316]), 32'hFF);
    run(len, -1);
    chk("seg3_dout", 32'(dout), 32'hFF);
    chk("seg3_done", 32'(n_done), 32'd4);
    chk("seg3_err", 32'(n_err), 32'd1);
    len = 0;
    push(1'b1, 3);
    frame(8'hC3, 1'b1);
    push(1'b1, 12);
    model();
    run(len, 3 + 70);
    chk("seg4_dout", 32'(dout), 32'hC3);
    chk("seg4_done", 32'(n_done), 32'd5);
    len = 0;
    for (int f = 0; f < 25; f++) begin
      push(1'b1, int'($urandom_range(1, 15)));
      if ($urandom_range(0, 3) == 0) begin
        push(1'b0, int'($urandom_range(1, 7)));
        push(1'b1, int'($urandom_range(1, 8)));
      end
      frame(8'($urandom), $urandom_range(0, 4) != 0);
    end
    push(1'b1, 160);
    model();
    nd = n_done;
    ne = n_err;
    for (int i = 0; i < len; i++) begin
      nd += int'(evt[i] == 1);
      ne += int'(evt[i] == 2);
    end
    run(len, -1);
    chk("rand_done", 32'(n_done), 32'(nd));
    chk("rand_err", 32'(n_err), 32'(ne));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
